// File: rtl/delta_pkg.sv
// Shared definitions for the delta-modulation spike link (encoder and reconstructor).
package delta_pkg;

    // Two-bit spike code: bit 1 = up, bit 0 = down.
    localparam logic [1:0] SPIKE_NONE = 2'b00;
    localparam logic [1:0] SPIKE_DOWN = 2'b01;
    localparam logic [1:0] SPIKE_UP   = 2'b10;
    localparam logic [1:0] SPIKE_BAD  = 2'b11;

    // Run-control FSM state.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/delta_leak_timer.sv
// Idle-cycle counter: emits a one-cycle terminal pulse on the CYCLES-th advance.
// CYCLES = 0 turns the timer off entirely (no pulse ever).
module delta_leak_timer #(
    parameter int CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_adv,
    output logic o_tick
);

    localparam int CW = (CYCLES < 2) ? 1 : $clog2(CYCLES);
    localparam logic [CW-1:0] LAST = CW'((CYCLES == 0) ? 0 : CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          w_adv;

    assign w_adv  = (CYCLES != 0) && i_adv;
    assign o_tick = w_adv && !i_clr && (r_cnt == LAST);

    // Count advances; clear wins over advance, wrap to zero on the terminal count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (w_adv) begin
            if (r_cnt == LAST) r_cnt <= '0;
            else               r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/delta_reconstruct.sv
// Delta-modulation receiver: integrates up/down spikes of size step into a
// saturating estimate, with an optional idle leak toward zero.
module delta_reconstruct
    import delta_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int STEP_W      = 4,
    parameter int LEAK_CYCLES = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_val,
    input  logic [STEP_W-1:0] i_step,
    input  logic [1:0]        i_spike,
    input  logic              i_in_valid,
    output logic [DATA_W-1:0] o_recon,
    output logic              o_out_valid,
    output logic              o_sat_hi,
    output logic              o_sat_lo,
    output logic              o_err
);

    state_t            r_state;
    logic              r_live;      // low for the first edge after reset release
    logic [DATA_W-1:0] r_recon;
    logic              r_out_valid;
    logic              r_sat_hi;
    logic              r_sat_lo;
    logic              r_err;

    logic              w_run;
    logic              w_load;
    logic              w_acc;
    logic              w_move;
    logic              w_bad;
    logic              w_adv;
    logic              w_clr;
    logic              w_tick;
    logic [DATA_W:0]   w_ext;
    logic [DATA_W:0]   w_stepx;
    logic [DATA_W:0]   w_wide;
    logic [DATA_W-1:0] w_next;
    logic              w_hi;
    logic              w_lo;

    // en low also blocks the cycle in which the FSM is still RUN but leaving.
    assign w_run   = r_live && (r_state == RUN) && i_en;
    assign w_load  = r_live && i_load;
    assign w_acc   = w_run && i_in_valid && !i_load;
    assign w_move  = w_acc && ((i_spike == SPIKE_UP) || (i_spike == SPIKE_DOWN));
    assign w_bad   = w_acc && (i_spike == SPIKE_BAD);
    assign w_adv   = w_run && !i_load && !w_move;
    assign w_clr   = w_load || w_move;

    assign w_ext   = {1'b0, r_recon};
    assign w_stepx = {{(DATA_W + 1 - STEP_W){1'b0}}, i_step};

    delta_leak_timer #(
        .CYCLES (LEAK_CYCLES)
    ) u_leak (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_adv   (w_adv),
        .o_tick  (w_tick)
    );

    // Saturating add/subtract in DATA_W+1 bits; the extra bit flags carry/borrow.
    always_comb begin
        w_wide = w_ext;
        w_next = r_recon;
        w_hi   = 1'b0;
        w_lo   = 1'b0;
        if (i_spike == SPIKE_UP) begin
            w_wide = w_ext + w_stepx;
            if (w_wide[DATA_W]) begin
                w_next = '1;
                w_hi   = 1'b1;
            end else begin
                w_next = w_wide[DATA_W-1:0];
            end
        end else begin
            w_wide = w_ext - w_stepx;
            if (w_wide[DATA_W]) begin
                w_next = '0;
                w_lo   = 1'b1;
            end else begin
                w_next = w_wide[DATA_W-1:0];
            end
        end
    end

    // Run-control FSM: follows en; r_live holds off updates for one edge after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_live  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                IDLE:    if (i_en)  r_state <= RUN;
                RUN:     if (!i_en) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Estimate update with priority load > spike > leak; flags move only on load/spike.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_recon     <= '0;
            r_out_valid <= 1'b0;
            r_sat_hi    <= 1'b0;
            r_sat_lo    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_load) begin
                r_recon     <= i_load_val;
                r_out_valid <= 1'b1;
                r_sat_hi    <= 1'b0;
                r_sat_lo    <= 1'b0;
                r_err       <= 1'b0;
            end else if (w_move) begin
                r_recon     <= w_next;
                r_out_valid <= (w_next != r_recon);
                r_sat_hi    <= w_hi;
                r_sat_lo    <= w_lo;
            end else begin
                if (w_bad) r_err <= 1'b1;
                if (w_tick && (r_recon != '0)) begin
                    r_recon     <= r_recon - DATA_W'(1);
                    r_out_valid <= 1'b1;
                end
            end
        end
    end

    assign o_recon     = r_recon;
    assign o_out_valid = r_out_valid;
    assign o_sat_hi    = r_sat_hi;
    assign o_sat_lo    = r_sat_lo;
    assign o_err       = r_err;

endmodule

// File: tb/tb_delta_reconstruct.sv
// Self-checking bench for delta_reconstruct: directed table, hand sequences, random vs model.
module tb_delta_reconstruct;

    localparam int DW   = 8;
    localparam int SW   = 4;
    localparam int LEAK = 16;
    localparam int MAXV = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, load, in_valid;
    logic [DW-1:0] load_val;
    logic [SW-1:0] step;
    logic [1:0]    spike;
    logic [DW-1:0] recon;
    logic          out_valid, sat_hi, sat_lo, err;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state (plain integers, spec-level behaviour)
    int m_recon;
    bit m_ov, m_hi, m_lo, m_err, m_run, m_live;
    int m_idle;

    delta_reconstruct #(.DATA_W(DW), .STEP_W(SW), .LEAK_CYCLES(LEAK)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_load      (load),
        .i_load_val  (load_val),
        .i_step      (step),
        .i_spike     (spike),
        .i_in_valid  (in_valid),
        .o_recon     (recon),
        .o_out_valid (out_valid),
        .o_sat_hi    (sat_hi),
        .o_sat_lo    (sat_lo),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_recon = 0; m_ov = 0; m_hi = 0; m_lo = 0; m_err = 0;
        m_run = 0; m_live = 0; m_idle = 0;
    endtask

    // One clock edge of the reference model, using the inputs currently applied.
    task automatic model_step();
        int v;
        bit act;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_ov = 0;
        act  = m_live && m_run && en;
        if (load && m_live) begin
            m_recon = load_val; m_ov = 1; m_hi = 0; m_lo = 0; m_err = 0; m_idle = 0;
        end else if (act && in_valid && (spike == 2'b10 || spike == 2'b01)) begin
            v = (spike == 2'b10) ? m_recon + int'(step) : m_recon - int'(step);
            m_hi = (v > MAXV);
            m_lo = (v < 0);
            if (v > MAXV) v = MAXV;
            if (v < 0)    v = 0;
            m_ov    = (v != m_recon);
            m_recon = v;
            m_idle  = 0;
        end else if (act) begin
            if (in_valid && spike == 2'b11) m_err = 1;
            m_idle++;
            if (m_idle == LEAK) begin
                m_idle = 0;
                if (m_recon > 0) begin
                    m_recon--;
                    m_ov = 1;
                end
            end
        end
        m_run  = en;
        m_live = 1;
    endtask

    task automatic chk(input string nm, input int er, input bit eov, input bit ehi,
                       input bit elo, input bit eerr);
        n_chk++;
        if (recon !== DW'(er) || out_valid !== eov || sat_hi !== ehi ||
            sat_lo !== elo || err !== eerr) begin
            n_err++;
            $display("FAIL %s: got recon=%0d ov=%b hi=%b lo=%b err=%b, want recon=%0d ov=%b hi=%b lo=%b err=%b",
                     nm, recon, out_valid, sat_hi, sat_lo, err, er, eov, ehi, elo, eerr);
        end
    endtask

    task automatic chk_model(input string nm);
        chk(nm, m_recon, m_ov, m_hi, m_lo, m_err);
    endtask

    // Advance one edge, update model, sample 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit e, input bit ld, input int lv, input int st,
                         input bit [1:0] sp, input bit iv);
        en = e; load = ld; load_val = DW'(lv); step = SW'(st); spike = sp; in_valid = iv;
    endtask

    typedef struct {
        bit       en;
        bit       ld;
        int       lv;
        int       st;
        bit [1:0] sp;
        bit       iv;
        int       er;
        bit       eov, ehi, elo, eerr;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int exp_r;
        bit exp_ov;

        //            en ld  lv   st sp     iv  rec  ov hi lo err
        tbl[0]  = '{1, 0, 0,   0, 2'b00, 0, 0,   0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0,   3, 2'b10, 1, 3,   1, 0, 0, 0};
        tbl[2]  = '{1, 0, 0,   3, 2'b10, 1, 6,   1, 0, 0, 0};
        tbl[3]  = '{1, 0, 0,   3, 2'b10, 1, 9,   1, 0, 0, 0};
        tbl[4]  = '{1, 0, 0,   3, 2'b10, 1, 12,  1, 0, 0, 0};
        tbl[5]  = '{1, 0, 0,   3, 2'b10, 1, 15,  1, 0, 0, 0};
        tbl[6]  = '{1, 1, 250, 0, 2'b00, 0, 250, 1, 0, 0, 0};
        tbl[7]  = '{1, 0, 0,  10, 2'b10, 1, 255, 1, 1, 0, 0};
        tbl[8]  = '{1, 0, 0,   5, 2'b01, 1, 250, 1, 0, 0, 0};
        tbl[9]  = '{1, 1, 2,   0, 2'b00, 0, 2,   1, 0, 0, 0};
        tbl[10] = '{1, 0, 0,   7, 2'b01, 1, 0,   1, 0, 1, 0};
        tbl[11] = '{1, 0, 0,   7, 2'b01, 1, 0,   0, 0, 1, 0};
        tbl[12] = '{1, 1, 40,  0, 2'b00, 0, 40,  1, 0, 0, 0};
        tbl[13] = '{1, 0, 0,   3, 2'b11, 1, 40,  0, 0, 0, 1};
        tbl[14] = '{1, 0, 0,   3, 2'b00, 1, 40,  0, 0, 0, 1};
        tbl[15] = '{1, 1, 7,   0, 2'b00, 0, 7,   1, 0, 0, 0};
        tbl[16] = '{1, 0, 0,   0, 2'b10, 1, 7,   0, 0, 0, 0};
        tbl[17] = '{0, 0, 0,   5, 2'b10, 1, 7,   0, 0, 0, 0};
        tbl[18] = '{0, 0, 0,   5, 2'b10, 1, 7,   0, 0, 0, 0};
        tbl[19] = '{1, 1, 100, 0, 2'b00, 0, 100, 1, 0, 0, 0};

        // Reset state, asserted asynchronously before any edge
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 2'b00, 0);
        model_reset();
        #2;
        chk("reset_async", 0, 0, 0, 0, 0);
        #10 rst_n = 1'b1;
        cyc(); chk_model("post_reset0");
        cyc(); chk_model("post_reset1");

        // Directed table
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].en, tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].sp, tbl[i].iv);
            cyc();
            chk($sformatf("tbl[%0d]", i), tbl[i].er, tbl[i].eov, tbl[i].ehi, tbl[i].elo, tbl[i].eerr);
            chk_model($sformatf("tbl_model[%0d]", i));
        end

        // Leak: 32 idle cycles from 5
        drive(1, 1, 5, 0, 2'b00, 0);
        cyc(); chk("leak_load", 5, 1, 0, 0, 0);
        for (int i = 1; i <= 32; i++) begin
            drive(1, 0, 0, 3, 2'b00, 1);
            cyc();
            exp_r  = (i < 16) ? 5 : (i < 32) ? 4 : 3;
            exp_ov = (i == 16) || (i == 32);
            chk($sformatf("leak_idle[%0d]", i), exp_r, exp_ov, 0, 0, 0);
        end

        // Leak restart: an UP at cycle 10 restarts the idle count
        drive(1, 1, 5, 0, 2'b00, 0);
        cyc(); chk("restart_load", 5, 1, 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            drive(1, 0, 0, 0, 2'b00, 0);
            cyc(); chk($sformatf("restart_pre[%0d]", i), 5, 0, 0, 0, 0);
        end
        drive(1, 0, 0, 1, 2'b10, 1);
        cyc(); chk("restart_up", 6, 1, 0, 0, 0);
        for (int j = 1; j <= 16; j++) begin
            drive(1, 0, 0, 0, 2'b00, 1);
            cyc();
            chk($sformatf("restart_post[%0d]", j), (j < 16) ? 6 : 5, j == 16, 0, 0, 0);
        end

        // en low with spikes streaming: estimate frozen
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 4, 2'b10, 1);
            cyc(); chk($sformatf("en_low[%0d]", i), 5, 0, 0, 0, 0);
        end

        // Mid-stream async reset, then reset-release latency with load held
        drive(1, 0, 0, 0, 2'b00, 0);
        cyc(); chk_model("rerun");
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 2, 2'b10, 1);
            cyc(); chk($sformatf("stream[%0d]", i), 7 + 2 * i, 1, 0, 0, 0);
        end
        #3 rst_n = 1'b0;
        #1 chk("reset_midstream", 0, 0, 0, 0, 0);
        model_reset();
        drive(0, 1, 77, 0, 2'b00, 0);
        cyc(); chk_model("held_reset");
        #1 rst_n = 1'b1;
        cyc(); chk("release_edge1", 0, 0, 0, 0, 0);
        cyc(); chk("release_edge2", 77, 1, 0, 0, 0);

        // Random: dense spikes
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0, $urandom_range(0, MAXV),
                  $urandom_range(0, 15), 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
            cyc(); chk_model($sformatf("rand_dense[%0d]", i));
        end
        // Random: sparse spikes so the leak fires
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 49) != 0, $urandom_range(0, 199) == 0, $urandom_range(0, 20),
                  $urandom_range(0, 15), 2'($urandom_range(0, 3)), $urandom_range(0, 24) == 0);
            cyc(); chk_model($sformatf("rand_sparse[%0d]", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
